ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Iterative RV32M divider (DIV/DIVU/REM/REMU) in the EX stage, downstream of the ID/EX pipeline register.
//  Takes operands and destination register from ID/EX; raises a hold request while computing.
//  Returns one result-valid pulse with the rd address for EX writeback muxing.
//  Radix-2 restoring algorithm, one quotient bit per clock.
// PARAMETERS
//  DATA_W   32   operand/result width; iteration count = DATA_W
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rstn         in   1       asynchronous active-low reset
//  start_i      in   1       request from EX decode: instruction in ID/EX is a divide
//  op_i         in   3       funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  dividend_i   in   DATA_W  rs1 data (ID/EX reg1_rdata)
//  divisor_i    in   DATA_W  rs2 data (ID/EX reg2_rdata)
//  reg_waddr_i  in   5       rd of the divide instruction
//  flush_i      in   1       jump/interrupt kill: abort current operation
//  busy_o       out  1       hold request to ctrl (drives Hold_Id-level stall)
//  ready_o      out  1       one-cycle pulse: result_o/reg_waddr_o valid, write rd
//  result_o     out  DATA_W  quotient or remainder
//  reg_waddr_o  out  5       rd latched at start
// BEHAVIOUR
//  - Reset (async, rstn=0): state IDLE, busy_o=0, ready_o=0, result_o=0, reg_waddr_o=0, count=0.
//  - States: IDLE, CALC, END. Encoded as localparams; one-hot or binary.
//  - IDLE: start_i=1 at edge E0 latches op, rd, |dividend| and |divisor|, and sign flags.
//    For unsigned ops and non-negative operands, values are used as-is; no negation is applied.
//    Next state is CALC, or END directly on a special case.
//  - busy_o = (state==CALC) | (state==IDLE & start_i & ~flush_i). The combinational term stalls the pipeline in the request cycle.
//  - CALC: each cycle shifts the remainder left one bit and brings in the next dividend bit.
//    If rem>=divisor: subtract and set the quotient bit.
//    count increments 0..DATA_W-1; at count==DATA_W-1 -> END.
//  - END: ready_o=1 for exactly one cycle, result_o/reg_waddr_o valid; busy_o=0; next state IDLE.
//    result_o holds its value until the next start.
//  - Latency: start sampled at E0 -> CALC in cycles 1..32 -> ready_o high in cycle 33 (DATA_W+1).
//  - Sign fix in END:
//    DIV quotient is negated iff the operand signs differ.
//    REM remainder takes the sign of the dividend.
//  - Special cases resolve in END at cycle 1 (no CALC):
//    divisor==0: quotient = all ones, remainder = dividend (signed and unsigned).
//    DIV/REM with dividend=0x80000000, divisor=0xFFFFFFFF: quotient 0x80000000, remainder 0.
//  - start_i while in CALC or END is ignored; there is no queueing.
//  - flush_i=1 in any state: next edge -> IDLE, count=0, no ready_o pulse; busy_o drops combinationally.
//    flush_i has priority over start_i in the same cycle.
//  - Reset mid-operation: immediate IDLE, no ready_o afterwards.
//  - All arithmetic is DATA_W+1 bits wide for the trial subtract.
//    The quotient register is DATA_W bits; no wrap beyond count DATA_W-1.
// STRUCTURE
//  - define.v gains: `INST_DIV/`INST_DIVU/`INST_REM/`INST_REMU funct3 codes and a `DivCntBus width macro.
//    Existing `RegWidthBus/`RegNumbBus/`Hold_Flag_Bus macros are reused.
//  - Single module. State, counter and data registers are written directly with async-reset always blocks.
//    gen_pipe_dff is not used: the registers have enable/feedback rather than pipe semantics. No sub-module.
//  - The ctrl unit ORs busy_o into its hold request. The EX writeback mux selects result_o when ready_o=1.
// TESTING
//  1. DIV 100/7 at E0 -> busy_o=1 cycles 0..32, ready_o only in cycle 33, result 14, reg_waddr_o=rd.
//  2. REM -7/2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF/16 -> 15.
//  3. DIV 5/0 -> ready_o in cycle 1, 0xFFFFFFFF; REMU 5/0 -> 5; REM 0x80000000/-1 -> 0; DIV same -> 0x80000000.
//  4. flush_i at cycle 10 of a DIV -> no ready_o ever; busy_o=0 next cycle.
//     A new start at cycle 12 gives its correct result at cycle 12+33.
//  5. start_i pulsed again during CALC -> ignored, first result unchanged.
//     Simultaneous flush_i+start_i in IDLE -> stays IDLE.
//  6. rstn low at cycle 20 -> outputs zero immediately. After release, a random DIV/REM regression (1000 ops)
//     matches the reference model, including signed corner values.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage iterative divider: funct3 codes and FSM state encoding.
package ex_div_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency DATA_W+1 cycles (1 for divide-by-zero/overflow); holds the pipeline via busy, no queueing.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        reg_waddr_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] dvd_q, dvs_q, quot_q, rem_q;
    logic              rem_sel_q, neg_q;

    // Operand decode in the request cycle
    logic              start_ok, is_signed, rem_sel, sign_a, sign_b, neg_res;
    logic              div_zero, overflow, special;
    logic [DATA_W-1:0] abs_a, abs_b, spec_res;

    assign start_ok  = start_i & ~flush_i;
    assign is_signed = (op_i == OP_DIV) | (op_i == OP_REM);
    assign rem_sel   = (op_i == OP_REM) | (op_i == OP_REMU);
    assign sign_a    = is_signed & dividend_i[DATA_W-1];
    assign sign_b    = is_signed & divisor_i[DATA_W-1];
    assign abs_a     = sign_a ? -dividend_i : dividend_i;
    assign abs_b     = sign_b ? -divisor_i  : divisor_i;
    assign neg_res   = rem_sel ? sign_a : (sign_a ^ sign_b);

    assign div_zero  = (divisor_i == '0);
    assign overflow  = is_signed & (dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                                 & (divisor_i == '1);
    assign special   = div_zero | overflow;
    // Both special cases leave the dividend as the quotient (overflow) or remainder (div-by-zero)
    assign spec_res  = div_zero ? (rem_sel ? dividend_i : '1)
                                : (rem_sel ? '0 : dividend_i);

    // One restoring step: trial subtract on DATA_W+1 bits
    logic [DATA_W:0]   shifted, diff;
    logic              take;
    logic [DATA_W-1:0] rem_nxt, quot_nxt, fin_res;

    assign shifted  = {rem_q, dvd_q[DATA_W-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign take     = ~diff[DATA_W];
    assign rem_nxt  = take ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quot_nxt = {quot_q[DATA_W-2:0], take};
    assign fin_res  = rem_sel_q ? (neg_q ? -rem_nxt  : rem_nxt)
                                : (neg_q ? -quot_nxt : quot_nxt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_i) state_nxt = special ? S_END : S_CALC;
                S_CALC:  if (count == CNT_LAST) state_nxt = S_END;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = ((state == S_CALC) & ~flush_i) | ((state == S_IDLE) & start_ok);
        ready_o = (state == S_END);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            rem_sel_q   <= 1'b0;
            neg_q       <= 1'b0;
            result_o    <= '0;
            reg_waddr_o <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (state == S_IDLE && start_i) begin
            count       <= '0;
            dvd_q       <= abs_a;
            dvs_q       <= abs_b;
            quot_q      <= '0;
            rem_q       <= '0;
            rem_sel_q   <= rem_sel;
            neg_q       <= neg_res;
            reg_waddr_o <= reg_waddr_i;
            if (special) result_o <= spec_res;
        end else if (state == S_CALC) begin
            dvd_q  <= {dvd_q[DATA_W-2:0], 1'b0};
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            if (count == CNT_LAST) begin
                count    <= '0;
                result_o <= fin_res;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Randomized self-checking bench for ex_div against a plain-arithmetic RV32M reference.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i, divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o, ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int n_chk  = 0;
    int n_fail = 0;

    ex_div dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (b == 32'd0) return (op[1]) ? a : 32'hFFFF_FFFF;
        case (op)
            3'b100:  r = sa / sb;
            3'b101:  r = ua / ub;
            3'b110:  r = sa % sb;
            default: r = ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one divide and follow it to its ready pulse; optionally re-pulse start mid-flight.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input bit chk_busy, input bit poke);
        logic [4:0] rd;
        int lat;
        bit seen;
        rd   = 5'($urandom_range(1, 31));
        lat  = ref_lat(op, a, b);
        seen = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
        #1;
        if (chk_busy) chk({tag, " busy c0"}, 32'(busy_o), 32'd1);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (poke && k == 5) begin
                start_i = 1'b1; op_i = 3'b101; dividend_i = 32'd9; divisor_i = 32'd3;
                reg_waddr_i = ~rd;
            end
            #1;
            if (ready_o) begin
                seen = 1'b1;
                chk({tag, " latency"}, 32'(k), 32'(lat));
                chk({tag, " result"}, result_o, exp);
                chk({tag, " rd"}, 32'(reg_waddr_o), 32'(rd));
                if (chk_busy) chk({tag, " busy end"}, 32'(busy_o), 32'd0);
            end else if (chk_busy) begin
                chk({tag, " busy calc"}, 32'(busy_o), 32'd1);
            end
        end
        start_i = 1'b0;
        if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    // Watch for a stray ready pulse over n cycles
    task automatic quiet(input string tag, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            if (ready_o || busy_o) bad++;
        end
        chk({tag, " quiet"}, 32'(bad), 32'd0);
    endtask

    logic [31:0] corners [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h8000_0001};

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        rstn = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 3'b100;
        dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
        #1;
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset ready", 32'(ready_o), 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset rd", 32'(reg_waddr_o), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        run_op("div100/7", 3'b100, 32'd100, 32'd7, 32'd14, 1'b1, 1'b0);
        run_op("rem-7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu max/1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("remu max/16", 3'b111, 32'hFFFF_FFFF, 32'd16, 32'd15, 1'b0, 1'b0);
        run_op("div5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("remu5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

        // Flush mid-calculation, then a fresh divide two cycles later
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush ready", 32'(ready_o), 32'd0);
        run_op("after flush", 3'b100, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0);

        run_op("start in calc", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);

        // Flush and start together in IDLE
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; dividend_i = 32'd8; divisor_i = 32'd2;
        #1;
        chk("flush+start busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        quiet("flush+start", 40);

        // Asynchronous reset at cycle 20 of an operation
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; dividend_i = 32'd77; divisor_i = 32'd5; reg_waddr_i = 5'd9;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst ready", 32'(ready_o), 32'd0);
        chk("rst result", result_o, 32'd0);
        chk("rst rd", 32'(reg_waddr_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        quiet("post rst", 40);

        for (int i = 0; i < 1000; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            case ($urandom_range(0, 5))
                0:       b = corners[$urandom_range(0, 7)];
                1:       b = 32'($urandom_range(0, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("rand", op, a, b, ref_div(op, a, b), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
